// File: rtl/neuron_feeder_if.sv
// Neuron feeder bus: command, weight memory,
// activation stream, neuron drive and result port.
interface neuron_feeder_if #(
  parameter int BITWIDTH = 16,
  parameter int MAX_LEN  = 1024
);
  localparam int BW = BITWIDTH + 2 - 1;
  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic          start;
  logic [LW-1:0] start_len;
  logic [AW-1:0] start_base;
  logic          busy;
  logic          w_ren;
  logic [AW-1:0] w_addr;
  logic [BW:0]   w_rdata;
  logic          in_valid;
  logic          in_ready;
  logic [BW:0]   in_data;
  logic          n_clear;
  logic          n_en;
  logic [BW:0]   n_weight;
  logic [BW:0]   n_data;
  logic [BW:0]   n_accum;
  logic          out_valid;
  logic          out_ready;
  logic [BW:0]   out_data;

  modport master (
    input  start, start_len, start_base,
    input  w_rdata, in_valid, in_data,
    input  n_accum, out_ready,
    output busy, w_ren, w_addr, in_ready,
    output n_clear, n_en, n_weight, n_data,
    output out_valid, out_data
  );

  modport slave (
    output start, start_len, start_base,
    output w_rdata, in_valid, in_data,
    output n_accum, out_ready,
    input  busy, w_ren, w_addr, in_ready,
    input  n_clear, n_en, n_weight, n_data,
    input  out_valid, out_data
  );
endinterface

// File: rtl/neuron_feeder.sv
// Neuron feeder: clears the neuron, pairs prefetched
// weights with stream words, captures the dot product.
module neuron_feeder #(
  parameter int BITWIDTH = 16,
  parameter int MAX_LEN  = 1024
) (
  input logic            clk,
  input logic            rst,
  neuron_feeder_if.master bus
);
  localparam int BW = BITWIDTH + 2 - 1;
  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, RUN, DRAIN, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       len_q, len_d;
  logic [LW-1:0]       iss_q, iss_d;
  logic [LW-1:0]       hs_q, hs_d;
  logic [AW-1:0]       base_q, base_d;
  logic                rvalid_q, rvalid_d;
  logic [1:0][BW:0]    fifo_q, fifo_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                drain_q, drain_d;
  logic                n_clear_q, n_clear_d;
  logic                n_en_q, n_en_d;
  logic [BW:0]         n_weight_q, n_weight_d;
  logic [BW:0]         n_data_q, n_data_d;
  logic [BW:0]         out_data_q, out_data_d;

  logic                in_rdy;
  logic                pop;
  logic                push;
  logic                issue;
  logic [2:0]          occ;

  // Next-state, prefetch FIFO and neuron drive
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    iss_d      = iss_q;
    hs_d       = hs_q;
    base_d     = base_q;
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    n_clear_d  = 1'b0;
    n_en_d     = 1'b0;
    n_weight_d = n_weight_q;
    n_data_d   = n_data_q;
    out_data_d = out_data_q;
    drain_d    = 1'b0;

    in_rdy = (state_q == RUN) && (cnt_q != 2'd0);
    pop    = in_rdy && bus.in_valid;
    push   = rvalid_q;
    occ    = 3'(cnt_q) + 3'(rvalid_q) - 3'(pop);
    issue  = ((state_q == CLEAR) || (state_q == RUN))
          && (iss_q != len_q)
          && (occ < 3'd2);
    rvalid_d = issue;
    cnt_d    = cnt_q + 2'(push) - 2'(pop);

    if (issue) iss_d = iss_q + 1'b1;

    if (push) begin
      fifo_d[wr_ptr_q] = bus.w_rdata;
      wr_ptr_d         = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d   = ~rd_ptr_q;
      n_en_d     = 1'b1;
      n_weight_d = fifo_q[rd_ptr_q];
      n_data_d   = bus.in_data;
      hs_d       = hs_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = CLEAR;
          len_d     = bus.start_len;
          base_d    = bus.start_base;
          iss_d     = '0;
          hs_d      = '0;
          n_clear_d = 1'b1;
        end
      end
      CLEAR: begin
        state_d = (len_q == '0) ? DRAIN : RUN;
      end
      RUN: begin
        if (pop && ((hs_q + 1'b1) == len_q))
          state_d = DRAIN;
      end
      DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) begin
          out_data_d = bus.n_accum;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      iss_q      <= '0;
      hs_q       <= '0;
      base_q     <= '0;
      rvalid_q   <= 1'b0;
      fifo_q     <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      drain_q    <= 1'b0;
      n_clear_q  <= 1'b0;
      n_en_q     <= 1'b0;
      n_weight_q <= '0;
      n_data_q   <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      iss_q      <= iss_d;
      hs_q       <= hs_d;
      base_q     <= base_d;
      rvalid_q   <= rvalid_d;
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      n_clear_q  <= n_clear_d;
      n_en_q     <= n_en_d;
      n_weight_q <= n_weight_d;
      n_data_q   <= n_data_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.w_ren     = issue;
  assign bus.w_addr    = base_q + AW'(iss_q);
  assign bus.in_ready  = in_rdy;
  assign bus.n_clear   = n_clear_q;
  assign bus.n_en      = n_en_q;
  assign bus.n_weight  = n_weight_q;
  assign bus.n_data    = n_data_q;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_data_q;
endmodule
